// File: rtl/uart_frame_pkg.sv
// Shared constants, state type and frame builder for the UART frame sequencer.
package uart_frame_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned SEL_W   = 4;

  localparam logic [SEL_W-1:0]   IDX_START  = 4'd0;
  localparam logic [SEL_W-1:0]   IDX_STOP   = 4'd9;
  localparam logic [SEL_W-1:0]   IDX_IDLE   = 4'd15;
  localparam logic [FRAME_W-1:0] FRAME_IDLE = 16'hFFFF;

  typedef enum logic {IDLE, SEND} state_e;

  // Start bit at 0, data LSB first at 8:1, stop bit at 9, mark on 15:10.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] d);
    return {6'b111111, 1'b1, d, 1'b0};
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Baud-rate tick generator: pulses tick on the last cycle of each bit period.
module baud_tick #(
  parameter int unsigned baud_div = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (baud_div > 1) ? $clog2(baud_div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(baud_div - 1);

  logic [CntW-1:0] r_count;

  assign tick = (r_count == CntMax);

  // Compare-based wrap so non-power-of-two dividers keep exact bit length.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_seq.sv
// UART transmit sequencer: latches a byte into a 16-channel frame and steps the
// channel select through it at the baud rate.
module uart_frame_seq
  import uart_frame_pkg::*;
#(
  parameter int unsigned baud_div = 104
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data,
  input  logic               start,
  output logic               ready,
  output logic               busy,
  output logic [FRAME_W-1:0] frame,
  output logic [SEL_W-1:0]   sel,
  output logic               tx
);

  state_e             r_state;
  logic               r_ready;
  logic [FRAME_W-1:0] r_frame;
  logic [SEL_W-1:0]   r_sel;

  logic w_accept;
  logic w_tick;

  assign w_accept = start && r_ready;

  // Bit timer restarts on accept so bit 0 gets a full period.
  baud_tick #(
    .baud_div(baud_div)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .clr (w_accept),
    .tick(w_tick)
  );

  // Frame FSM: accept in IDLE, advance sel on each tick in SEND.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_sel   <= IDX_IDLE;
      r_frame <= FRAME_IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_frame <= build_frame(data);
            r_sel   <= IDX_START;
            r_ready <= 1'b0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_tick) begin
            if (r_sel == IDX_STOP) begin
              r_sel   <= IDX_IDLE;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_sel <= r_sel + SEL_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = ~r_ready;
  assign frame = r_frame;
  assign sel   = r_sel;
  assign tx    = r_frame[r_sel];

endmodule
